// File: rtl/wb_poll_master_pkg.sv
// Shared types and bus widths for the Wishbone polling master.
package wb_poll_master_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP,
    WRITE
  } wb_master_state_t;

endpackage

// File: rtl/wb_poll_master_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wb_poll_master_if;
  import wb_poll_master_pkg::*;

  logic [WB_ADDR_W-1:0] adr;
  logic [WB_DATA_W-1:0] dat_w;
  logic [WB_DATA_W-1:0] dat_r;
  logic                 we;
  logic [WB_SEL_W-1:0]  sel;
  logic                 stb;
  logic                 cyc;
  logic                 ack;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_poll_master_poll_timer.sv
// Wrapping 0..PERIOD-1 counter; cleared and held at 0 whenever run is low.
module poll_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign tick = (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (!run) begin
      count_next = '0;
    end else if (tick) begin
      count_next = '0;
    end else begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wb_poll_master.sv
// Periodically reads SRC_ADDR and copies the value to DST_ADDR when it
// changed (or has never been written), with a per-transfer ack timeout.
module wb_poll_master
  import wb_poll_master_pkg::*;
#(
  parameter int                   POLL_PERIOD = 1_000_000,
  parameter int                   TIMEOUT     = 16,
  parameter logic [WB_ADDR_W-1:0] SRC_ADDR    = 32'h0000_0000,
  parameter logic [WB_ADDR_W-1:0] DST_ADDR    = 32'h0000_0010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  wb_poll_master_if.master     wb,
  output logic [WB_DATA_W-1:0] value_o,
  output logic                 busy_o,
  output logic                 err_o
);

  wb_master_state_t     state_reg, state_next;
  logic                 cyc_reg, cyc_next;
  logic                 stb_reg, stb_next;
  logic                 we_reg, we_next;
  logic [WB_ADDR_W-1:0] adr_reg, adr_next;
  logic [WB_DATA_W-1:0] dat_w_reg, dat_w_next;
  logic [WB_DATA_W-1:0] rd_reg, rd_next;
  logic [WB_DATA_W-1:0] value_reg, value_next;
  logic                 written_reg, written_next;
  logic                 err_reg, err_next;
  logic                 poll_tick;
  logic                 wait_tick;
  logic                 ack_valid;

  poll_timer #(.PERIOD(POLL_PERIOD)) u_poll_timer (
    .clk  (clk_i),
    .srst (rst_i),
    .run  (enable_i),
    .tick (poll_tick)
  );

  // Counts cycles with cyc high; the gap cycle clears it between transfers.
  poll_timer #(.PERIOD(TIMEOUT)) u_wait_timer (
    .clk  (clk_i),
    .srst (rst_i),
    .run  (cyc_reg),
    .tick (wait_tick)
  );

  assign ack_valid = cyc_reg && wb.ack;

  always_comb begin
    state_next   = state_reg;
    cyc_next     = cyc_reg;
    stb_next     = stb_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    dat_w_next   = dat_w_reg;
    rd_next      = rd_reg;
    value_next   = value_reg;
    written_next = written_reg;
    err_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (poll_tick && enable_i) begin
          state_next = READ;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = SRC_ADDR;
        end
      end
      READ: begin
        // Ack is checked before the timeout so a coincident ack wins.
        if (ack_valid) begin
          rd_next    = wb.dat_r;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          state_next = ((wb.dat_r != value_reg) || !written_reg) ? GAP : IDLE;
        end else if (wait_tick) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        state_next = WRITE;
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = 1'b1;
        adr_next   = DST_ADDR;
        dat_w_next = rd_reg;
      end
      WRITE: begin
        if (ack_valid) begin
          value_next   = rd_reg;
          written_next = 1'b1;
          cyc_next     = 1'b0;
          stb_next     = 1'b0;
          we_next      = 1'b0;
          state_next   = IDLE;
        end else if (wait_tick) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cyc_reg     <= 1'b0;
      stb_reg     <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_w_reg   <= '0;
      rd_reg      <= '0;
      value_reg   <= '0;
      written_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cyc_reg     <= cyc_next;
      stb_reg     <= stb_next;
      we_reg      <= we_next;
      adr_reg     <= adr_next;
      dat_w_reg   <= dat_w_next;
      rd_reg      <= rd_next;
      value_reg   <= value_next;
      written_reg <= written_next;
      err_reg     <= err_next;
    end
  end

  assign wb.cyc   = cyc_reg;
  assign wb.stb   = stb_reg;
  assign wb.we    = we_reg;
  assign wb.adr   = adr_reg;
  assign wb.dat_w = dat_w_reg;
  assign wb.sel   = '1;

  assign value_o = value_reg;
  assign busy_o  = (state_reg != IDLE);
  assign err_o   = err_reg;

endmodule

// File: tb/tb_wb_poll_master.sv
// Directed bench for wb_poll_master with a simple delayed-ack slave model.
module tb_wb_poll_master;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] value_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  wb_poll_master_if wb();

  wb_poll_master #(
    .POLL_PERIOD (8),
    .TIMEOUT     (4),
    .SRC_ADDR    (32'h0000_0000),
    .DST_ADDR    (32'h0000_0010)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .wb       (wb),
    .value_o  (value_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  // Slave: acks after ack_delay cycles of stb; can refuse all acks or writes only.
  logic [31:0] rd_data;
  int          ack_delay;
  logic        no_ack;
  logic        no_ack_wr;
  int          wait_cnt = 0;

  always @(posedge clk) begin
    if (wb.cyc && wb.stb) wait_cnt <= wait_cnt + 1;
    else                  wait_cnt <= 0;
  end

  assign wb.ack   = wb.cyc && wb.stb && (wait_cnt == ack_delay) && !no_ack && !(no_ack_wr && wb.we);
  assign wb.dat_r = rd_data;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: one line per completed transfer or error pulse.
  int          ncyc = 0;
  int          rise_cnt = 0;
  int          rd_rise = 0;
  int          wr_rise = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          we_cycles = 0;
  int          err_cnt = 0;
  logic [31:0] last_wr_adr = '0;
  logic [31:0] last_wr_dat = '0;
  logic        cyc_prev = 1'b0;
  logic        we_prev = 1'b0;
  logic [31:0] adr_prev = '0;

  always @(negedge clk) begin
    ncyc++;
    if (wb.cyc && !cyc_prev) begin
      rise_cnt++;
      if (wb.we) wr_rise = ncyc;
      else       rd_rise = ncyc;
    end
    if (wb.cyc && cyc_prev) begin
      check_eq("adr_stable", wb.adr, adr_prev);
      check_eq("we_stable", {31'd0, wb.we}, {31'd0, we_prev});
    end
    if (wb.cyc && wb.we) we_cycles++;
    if (wb.cyc && wb.ack) begin
      if (wb.we) begin
        wr_cnt++;
        last_wr_adr = wb.adr;
        last_wr_dat = wb.dat_w;
        $display("cycle %0d: WRITE adr=%h data=%h", ncyc, wb.adr, wb.dat_w);
      end else begin
        rd_cnt++;
        $display("cycle %0d: READ  adr=%h data=%h", ncyc, wb.adr, wb.dat_r);
      end
    end
    if (err_o === 1'b1) begin
      err_cnt++;
      $display("cycle %0d: ack timeout on adr=%h", ncyc, wb.adr);
    end
    cyc_prev = (wb.cyc === 1'b1);
    we_prev  = (wb.we === 1'b1);
    adr_prev = wb.adr;
  end

  task automatic wait_cyc(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb.cyc !== 1'b1 && n < bound);
    check_eq("cyc_seen", {31'd0, wb.cyc}, 32'd1);
  endtask

  task automatic wait_we(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb.cyc === 1'b1 && wb.we === 1'b1) && n < bound);
    check_eq("write_seen", {31'd0, wb.we}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, t0, e0, w0, r0, we0;
    rst_i     = 1'b1;
    enable_i  = 1'b0;
    rd_data   = 32'h0000_00A5;
    ack_delay = 1;
    no_ack    = 1'b0;
    no_ack_wr = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_cyc", {31'd0, wb.cyc}, 32'd0);
    check_eq("rst_stb", {31'd0, wb.stb}, 32'd0);
    check_eq("rst_we", {31'd0, wb.we}, 32'd0);
    check_eq("rst_adr", wb.adr, 32'd0);
    check_eq("rst_dat_w", wb.dat_w, 32'd0);
    check_eq("rst_sel", {28'd0, wb.sel}, 32'hF);
    check_eq("rst_value", value_o, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_o}, 32'd0);

    // First poll after reset always writes.
    rst_i    = 1'b0;
    enable_i = 1'b1;
    wait_cyc(40, n);
    check_eq("first_poll_lat", n, 32'd8);
    check_eq("read_adr", wb.adr, 32'h0000_0000);
    check_eq("read_we", {31'd0, wb.we}, 32'd0);
    check_eq("read_stb", {31'd0, wb.stb}, 32'd1);
    check_eq("busy_in_read", {31'd0, busy_o}, 32'd1);
    wait_idle(40);
    check_eq("wr_cnt_1", wr_cnt, 32'd1);
    check_eq("wr_adr", last_wr_adr, 32'h0000_0010);
    check_eq("wr_dat_a5", last_wr_dat, 32'h0000_00A5);
    check_eq("value_a5", value_o, 32'h0000_00A5);
    check_eq("read_to_write", wr_rise - rd_rise, 32'd3);

    // Unchanged data: read only.
    we0 = we_cycles;
    r0  = rd_cnt;
    wait_cyc(20, n);
    wait_idle(20);
    check_eq("same_rd_cnt", rd_cnt, r0 + 1);
    check_eq("same_no_we", we_cycles, we0);
    check_eq("same_value", value_o, 32'h0000_00A5);

    // Changed data is written on the next poll.
    rd_data = 32'h0000_003C;
    wait_cyc(20, n);
    wait_idle(20);
    check_eq("chg_wr_cnt", wr_cnt, 32'd2);
    check_eq("chg_wr_dat", last_wr_dat, 32'h0000_003C);
    check_eq("chg_value", value_o, 32'h0000_003C);

    // Read never acked: timeout after 4 cycles with a one-cycle err pulse.
    no_ack = 1'b1;
    e0 = err_cnt;
    w0 = wr_cnt;
    wait_cyc(20, n);
    k = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb.cyc !== 1'b1) break;
      k++;
    end
    check_eq("timeout_len", k, 32'd4);
    check_eq("err_pulse", {31'd0, err_o}, 32'd1);
    @(negedge clk);
    check_eq("err_one_cycle", {31'd0, err_o}, 32'd0);
    check_eq("busy_after_to", {31'd0, busy_o}, 32'd0);
    t0 = rd_rise;
    no_ack = 1'b0;
    wait_cyc(12, n);
    wait_idle(20);
    check_eq("repoll_spacing", rd_rise - t0, 32'd8);
    check_eq("to_err_cnt", err_cnt, e0 + 1);
    check_eq("to_no_write", wr_cnt, w0);
    check_eq("to_value", value_o, 32'h0000_003C);

    // Ack coincident with timeout counts as success.
    ack_delay = 3;
    rd_data   = 32'h0000_005A;
    e0 = err_cnt;
    wait_cyc(20, n);
    wait_idle(40);
    check_eq("late_ack_no_err", err_cnt, e0);
    check_eq("late_ack_wr_dat", last_wr_dat, 32'h0000_005A);
    check_eq("late_ack_value", value_o, 32'h0000_005A);
    ack_delay = 1;

    // Reset while the write waits for ack.
    rd_data   = 32'h0000_0077;
    no_ack_wr = 1'b1;
    e0 = err_cnt;
    wait_we(40);
    rst_i = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_cyc", {31'd0, wb.cyc}, 32'd0);
    check_eq("mid_rst_stb", {31'd0, wb.stb}, 32'd0);
    check_eq("mid_rst_we", {31'd0, wb.we}, 32'd0);
    check_eq("mid_rst_value", value_o, 32'd0);
    check_eq("mid_rst_err", {31'd0, err_o}, 32'd0);
    rst_i     = 1'b0;
    no_ack_wr = 1'b0;
    rd_data   = 32'h0000_005A;
    w0 = wr_cnt;
    wait_cyc(40, n);
    check_eq("post_rst_lat", n, 32'd8);
    wait_idle(20);
    check_eq("post_rst_write", wr_cnt, w0 + 1);
    check_eq("post_rst_value", value_o, 32'h0000_005A);
    check_eq("post_rst_no_err", err_cnt, e0);

    // Disabled: no bus activity; re-enable gives a full period.
    enable_i = 1'b0;
    r0 = rise_cnt;
    repeat (20) @(negedge clk);
    check_eq("dis_no_cyc", rise_cnt, r0);
    check_eq("dis_busy", {31'd0, busy_o}, 32'd0);
    enable_i = 1'b1;
    wait_cyc(40, n);
    check_eq("reenable_lat", n, 32'd8);
    wait_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
